ebpf_dmem_arbiter: RTL

- Shares the single-port eBPF data memory (packet data, 2048 x 64-bit) between two requesters: the CPU load/store path and the host packet loader (MMIO side).
- Sits between both requesters and the data memory instance.
- Serialises accesses with a small FSM and arbitrates ties round-robin, with a host-priority override.
- Returns read data and a one-cycle acknowledge to the granted requester.

---
 rtl/ebpf_dmem_arbiter_if.sv | 50 +++++
 rtl/ebpf_dmem_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/ebpf_dmem_arbiter_if.sv
// Bus bundle between the eBPF data-memory arbiter, its two requesters
// (CPU load/store path, host packet loader) and the single-port data memory.
interface ebpf_dmem_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              host_pri;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_data_out;

    logic              busy;
    logic [CNT_W-1:0]  conflict_cnt;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  host_req, host_we, host_addr, host_wdata, host_pri,
        input  mem_data_out,
        output cpu_ack, cpu_rdata, host_ack, host_rdata,
        output mem_address, mem_data_in, mem_write_enable,
        output busy, conflict_cnt
    );

    // Requesters plus memory side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output host_req, host_we, host_addr, host_wdata, host_pri,
        output mem_data_out,
        input  cpu_ack, cpu_rdata, host_ack, host_rdata,
        input  mem_address, mem_data_in, mem_write_enable,
        input  busy, conflict_cnt
    );
endinterface

// File: rtl/ebpf_dmem_arbiter.sv
// Serialises CPU and host accesses to the single-port eBPF data memory:
// round-robin on ties unless host_pri forces the host to win.
module ebpf_dmem_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    ebpf_dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state;
    state_t             state_nx;

    logic               owner_host;
    logic               last_host;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  cpu_rdata_q;
    logic [DATA_W-1:0]  host_rdata_q;
    logic [CNT_W-1:0]   conflict_q;

    logic               any_req;
    logic               tie;
    logic               grant_host;

    // A tie goes to the host when forced, or when the CPU was granted last.
    assign any_req    = bus.cpu_req | bus.host_req;
    assign tie        = bus.cpu_req & bus.host_req;
    assign grant_host = bus.host_req & (~bus.cpu_req | bus.host_pri | ~last_host);

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: next-state is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any_req) state_nx = ACCESS;
            ACCESS:  state_nx = we_q ? DONE : WAIT_RD;
            WAIT_RD: state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // last_host resets high so the CPU takes the first tie after reset.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            owner_host   <= 1'b0;
            last_host    <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
            conflict_q   <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                owner_host <= grant_host;
                last_host  <= grant_host;
                we_q       <= grant_host ? bus.host_we    : bus.cpu_we;
                addr_q     <= grant_host ? bus.host_addr  : bus.cpu_addr;
                wdata_q    <= grant_host ? bus.host_wdata : bus.cpu_wdata;
            end

            if (state == IDLE && tie && conflict_q != '1) begin
                conflict_q <= conflict_q + CNT_ONE;
            end

            // Memory read data is valid the cycle after ACCESS presented the address.
            if (state == WAIT_RD) begin
                if (owner_host) begin
                    host_rdata_q <= bus.mem_data_out;
                end else begin
                    cpu_rdata_q  <= bus.mem_data_out;
                end
            end
        end
    end

    assign bus.mem_address      = addr_q;
    assign bus.mem_data_in      = wdata_q;
    assign bus.mem_write_enable = (state == ACCESS) & we_q;

    assign bus.cpu_ack          = (state == DONE) & ~owner_host;
    assign bus.host_ack         = (state == DONE) &  owner_host;
    assign bus.cpu_rdata        = cpu_rdata_q;
    assign bus.host_rdata       = host_rdata_q;

    assign bus.busy             = (state != IDLE);
    assign bus.conflict_cnt     = conflict_q;

endmodule
